// File: rtl/s0_rs_enc_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helper for the RS(K+4,K) encoder.
package s0_rs_enc_pkg;
  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam int         RS_NPAR = 4;
  // Taps of g(x)=x^4+0F x^3+36 x^2+78 x+40, index 3 feeds R3
  localparam logic [RS_NPAR-1:0][7:0] GEN_COEF = {8'h0F, 8'h36, 8'h78, 8'h40};

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b100
  } rs_state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, p;
    x = a;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY[7:0] : 8'h00);
    end
    return p;
  endfunction
endpackage

// File: rtl/s0_rs_enc_if.sv
// Symbol stream in / codeword stream out for the RS encoder.
interface s0_rs_enc_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_last);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/s0_rs_enc_gf2m8_cmul.sv
// GF(2^8) multiply by a constant; the loop folds to an XOR network.
module s0_rs_enc_gf2m8_cmul
  import s0_rs_enc_pkg::*;
#(
  parameter logic [7:0] C = 8'h01
) (
  input  logic [7:0] a,
  output logic [7:0] p
);
  assign p = gf_mul(a, C);
endmodule

// File: rtl/s0_rs_enc.sv
// Systematic RS(K_LEN+4, K_LEN) encoder: passes message symbols through, then emits 4 parity symbols.
module s0_rs_enc
  import s0_rs_enc_pkg::*;
#(
  parameter int K_LEN = 16,
  parameter int NPAR  = 4
) (
  input logic        clk,
  input logic        rstn,
  s0_rs_enc_if.slave bus
);
  localparam int CW = $clog2(K_LEN + 1);
  localparam int PW = $clog2(NPAR);

  rs_state_e            state, state_nxt;
  logic [NPAR-1:0][7:0] r, r_nxt, r_base, prod;
  logic [CW-1:0]        cnt, cnt_nxt, cnt_base, cnt_inc;
  logic [PW-1:0]        pidx, pidx_nxt;
  logic                 out_valid_nxt, out_last_nxt;
  logic [7:0]           out_data_nxt, fb;
  logic                 out_free, in_fire, par_fire;

  assign out_free     = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = rstn && (state != PARITY) && out_free;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign par_fire     = (state == PARITY) && out_free;

  // First symbol of a codeword always starts from a cleared LFSR/counter
  assign r_base   = (state == IDLE) ? '0 : r;
  assign cnt_base = (state == IDLE) ? '0 : cnt;
  assign cnt_inc  = cnt_base + CW'(1);
  assign fb       = bus.in_data ^ r_base[NPAR-1];

  for (genvar i = 0; i < NPAR; i++) begin : g_tap
    s0_rs_enc_gf2m8_cmul #(.C(GEN_COEF[i])) u_cmul (.a(fb), .p(prod[i]));
  end

  always_comb begin
    state_nxt     = state;
    r_nxt         = r;
    cnt_nxt       = cnt;
    pidx_nxt      = pidx;
    out_valid_nxt = bus.out_valid;
    out_data_nxt  = bus.out_data;
    out_last_nxt  = bus.out_last;
    if (out_free) begin
      out_valid_nxt = 1'b0;
      out_last_nxt  = 1'b0;
    end
    case (state)
      IDLE, DATA: begin
        if (state == IDLE) begin
          r_nxt   = '0;
          cnt_nxt = '0;
        end
        if (in_fire) begin
          r_nxt         = {r_base[NPAR-2:0], 8'h00} ^ prod;
          cnt_nxt       = cnt_inc;
          out_valid_nxt = 1'b1;
          out_data_nxt  = bus.in_data;
          state_nxt     = (cnt_inc == CW'(K_LEN)) ? PARITY : DATA;
        end
      end
      PARITY: begin
        if (par_fire) begin
          // Drain R3 first, zero-filling from the bottom
          r_nxt         = {r[NPAR-2:0], 8'h00};
          out_valid_nxt = 1'b1;
          out_data_nxt  = r[NPAR-1];
          pidx_nxt      = pidx + PW'(1);
          if (pidx == PW'(NPAR - 1)) begin
            out_last_nxt = 1'b1;
            state_nxt    = IDLE;
            pidx_nxt     = '0;
            cnt_nxt      = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      r             <= '0;
      cnt           <= '0;
      pidx          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 8'h00;
      bus.out_last  <= 1'b0;
    end else begin
      state         <= state_nxt;
      r             <= r_nxt;
      cnt           <= cnt_nxt;
      pidx          <= pidx_nxt;
      bus.out_valid <= out_valid_nxt;
      bus.out_data  <= out_data_nxt;
      bus.out_last  <= out_last_nxt;
    end
  end
endmodule

// File: doc/s0_rs_enc.md
S0_RS_ENC -- requirements
Module: s0_rs_enc

Interface
REQ-001 Parameter K_LEN, default 16, message symbols per codeword (legal range 1..251).
REQ-002 Parameter NPAR, default 4, parity symbols per codeword; fixed at 4 (t=2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rstn  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  in_data holds a valid message symbol.
REQ-006 in_data  input  8  message symbol, GF(2^8), highest-degree symbol first.
REQ-007 in_ready  output  1  block accepts in_data this cycle; transfer occurs when in_valid & in_ready.
REQ-008 out_valid  output  1  out_data holds a valid codeword symbol.
REQ-009 out_data  output  8  codeword symbol: K_LEN message symbols, then NPAR parity symbols.
REQ-010 out_last  output  1  high with the final parity symbol of a codeword.
REQ-011 out_ready  input  1  downstream accepts out_data; transfer occurs when out_valid & out_ready.

Function
REQ-012 Code: systematic RS(K_LEN+4, K_LEN) over GF(2^8), primitive polynomial 0x11D, generator g(x)=(x-a^0)(x-a^1)(x-a^2)(x-a^3)=x^4+0x0F x^3+0x36 x^2+0x78 x+0x40.
REQ-013 Parity is p(x)=m(x)·x^4 mod g(x), computed by a 4-stage LFSR (regs R3..R0, 8 bits each).
REQ-014 LFSR step on each accepted symbol: fb=in_data^R3; R3=R2^fb·0x0F; R2=R1^fb·0x36; R1=R0^fb·0x78; R0=fb·0x40.
REQ-015 FSM states: IDLE, DATA, PARITY; one-hot encoded.
REQ-016 IDLE: LFSR and symbol counter cleared; in_ready high when the output register is free; the first accepted symbol is processed and the FSM moves to DATA (or to PARITY if K_LEN=1).
REQ-017 DATA: each accepted symbol advances the LFSR and increments the counter; after the K_LEN-th accepted symbol, the FSM moves to PARITY.
REQ-018 PARITY: in_ready low; emits R3, R2, R1, R0 in that order, shifting the LFSR toward R3 with zero fill on each output transfer; after the 4th transfer, the FSM moves to IDLE.
REQ-019 The output register is a single stage: out_data/out_valid load on an input transfer or parity emission whenever !out_valid | out_ready.
REQ-020 in_ready = (state is IDLE or DATA) & (!out_valid | out_ready); it is combinational from out_ready.
REQ-021 Latency: an accepted message symbol appears on out_data, unmodified, on the next cycle.
REQ-022 Parity emission starts in the cycle after the last message symbol is loaded, without a bubble if out_ready is held high; the codeword takes K_LEN+4 cycles at full throughput.
REQ-023 Backpressure: while out_valid & !out_ready, out_data, out_last and all state hold; no symbol is lost or duplicated.
REQ-024 in_valid low during DATA stalls the FSM; the LFSR and counter hold.
REQ-025 out_last is asserted only with the 4th parity symbol; a new codeword may be accepted in the cycle after that symbol transfers.
REQ-026 Symbol counter: ceil(log2(K_LEN+1)) bits; no wrap within a codeword.

Reset
REQ-027 On rstn low, the block immediately enters IDLE; LFSR=0, counter=0, out_valid=0, out_data=0x00, out_last=0, and in_ready=0 while reset is held.
REQ-028 Reset asserted mid-codeword abandons the codeword; no partial parity is emitted after release.
REQ-029 After reset release, in_ready rises in the first cycle.

Structure
REQ-030 A shared package/include (rs_defines) holds: GF polynomial 0x11D, NPAR=4, generator coefficients 0x0F/0x36/0x78/0x40, FSM state encodings.
REQ-031 One sub-module is used: gf2m8_cmul (GF(2^8) multiply by a constant parameter), instantiated 4 times, one per generator tap.

Verification
REQ-032 K_LEN=16, all-zero message, out_ready=1 -> 16 zeros, then parity 0x00,0x00,0x00,0x00; out_last on cycle 20 of the output.
REQ-033 K_LEN=16, message fifteen 0x00 then 0x01 -> parity 0x0F,0x36,0x78,0x40.
REQ-034 Random messages, 1000 codewords -> the golden model matches, and r(a^j)=0x00 for j=0..3 on each output codeword.
REQ-035 Random out_ready (50%) and in_valid (70%) -> the output sequence is identical to the full-throughput run; out_data is stable while stalled.
REQ-036 rstn pulsed low after the 7th message symbol, then a fresh codeword is sent -> no out_last from the aborted codeword, and correct parity for the new codeword.
REQ-037 K_LEN=1, message 0x01 -> output 0x01, 0x0F, 0x36, 0x78, 0x40; back-to-back codewords run with no idle gap.
